// File: rtl/vector_mem_requester.sv
// Initiator for the 8-lane strided data memory: sequences load/store bursts one
// beat per cycle, range-checks every beat and returns load vectors on valid/ready.
module vector_mem_requester #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned LANES       = 8,
  parameter int unsigned PIX_SIZE    = 8,
  parameter int unsigned LANE_STRIDE = 8,
  parameter int unsigned MEM_DEPTH   = 51200,
  parameter int unsigned LEN_W       = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [ADDR_W-1:0]         req_stride,
  input  logic [LEN_W-1:0]          req_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [LANES*PIX_SIZE-1:0] wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LANES*PIX_SIZE-1:0] rsp_data,
  output logic                      rsp_last,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [LANES*PIX_SIZE-1:0] mem_wd,
  input  logic [LANES*PIX_SIZE-1:0] mem_rd
);

  localparam int unsigned        DATA_W  = LANES * PIX_SIZE;
  localparam int unsigned        SPAN    = (LANES - 1) * LANE_STRIDE;
  localparam logic [ADDR_W:0]    SPAN_X  = (ADDR_W+1)'(SPAN);
  localparam logic [ADDR_W:0]    LAST_OK = (ADDR_W+1)'(MEM_DEPTH - 1);
  localparam logic [LEN_W-1:0]   ONE     = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STORE
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [ADDR_W-1:0]  r_stride;
  logic [LEN_W-1:0]   r_cnt;

  logic               w_beat_oob;
  logic               w_cap;
  logic [ADDR_W-1:0]  w_next_addr;

  // Highest lane of the current beat, computed one bit wider so wrap cannot hide it.
  assign w_beat_oob  = (({1'b0, r_cur_addr} + SPAN_X) > LAST_OK);
  assign w_cap       = !rsp_valid || rsp_ready;
  assign w_next_addr = r_cur_addr + r_stride;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_stride   <= '0;
      r_cnt      <= '0;
      req_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      rsp_data   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wd     <= DATA_W'(0);
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_cur_addr <= req_addr;
            r_stride   <= req_stride;
            r_cnt      <= req_len;
            if (req_len == '0) begin
              done <= 1'b1;
            end else if (req_we) begin
              wr_ready <= 1'b1;
              r_state  <= S_STORE;
            end else begin
              mem_addr <= req_addr;
              r_state  <= S_LOAD;
            end
          end
        end

        // mem_addr tracks r_cur_addr so the combinational read is ready each cycle.
        S_LOAD: begin
          if (w_cap) begin
            if (r_cnt == '0) begin
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_IDLE;
            end else if (w_beat_oob) begin
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              err       <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              rsp_data   <= mem_rd;
              rsp_valid  <= 1'b1;
              rsp_last   <= (r_cnt == ONE);
              r_cur_addr <= w_next_addr;
              mem_addr   <= w_next_addr;
              r_cnt      <= r_cnt - ONE;
            end
          end
        end

        // Each accepted beat raises mem_we for exactly the following cycle.
        S_STORE: begin
          mem_we <= 1'b0;
          if (r_cnt == '0) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end else if (wr_valid && wr_ready) begin
            if (w_beat_oob) begin
              err      <= 1'b1;
              wr_ready <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= r_cur_addr;
              mem_wd     <= wr_data;
              r_cur_addr <= w_next_addr;
              r_cnt      <= r_cnt - ONE;
              if (r_cnt == ONE) begin
                wr_ready <= 1'b0;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_requester.sv
// Directed bench for vector_mem_requester with a byte-array memory that reads
// combinationally and commits writes on the falling clock edge.
module tb_vector_mem_requester;

  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned DATA_W    = 64;
  localparam int          MEM_DEPTH = 51200;

  logic               CLK = 1'b0;
  logic               RST;
  logic               req_valid, req_ready, req_we;
  logic [ADDR_W-1:0]  req_addr, req_stride;
  logic [LEN_W-1:0]   req_len;
  logic               wr_valid, wr_ready;
  logic [DATA_W-1:0]  wr_data;
  logic               rsp_valid, rsp_ready, rsp_last;
  logic [DATA_W-1:0]  rsp_data;
  logic               done, err;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wd, mem_rd;

  logic [7:0] mem [MEM_DEPTH];
  bit         mem_init = 1'b0;
  int         errors   = 0;
  int         checks   = 0;

  vector_mem_requester dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_stride(req_stride), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
  endfunction

  // Expected load vector from the known initial fill pattern.
  function automatic logic [63:0] exp_vec(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (a + 8*i < MEM_DEPTH) v[8*i +: 8] = pat(a + 8*i);
    return v;
  endfunction

  function automatic logic [63:0] mem_row(input int a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[a + 8*i];
    return v;
  endfunction

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 8; i++)
      if (int'(mem_addr) + 8*i < MEM_DEPTH) mem_rd[8*i +: 8] = mem[int'(mem_addr) + 8*i];
  end

  // Sole writer of the memory array: fill once, then falling-edge commits.
  always @(negedge CLK) begin
    if (!mem_init) begin
      for (int a = 0; a < MEM_DEPTH; a++) mem[a] = pat(a);
      mem_init = 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < 8; i++)
        if (int'(mem_addr) + 8*i < MEM_DEPTH) mem[int'(mem_addr) + 8*i] = mem_wd[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [ADDR_W-1:0] stride, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_stride = stride; req_len = len;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_stride = '0;
    req_len = '0; wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_done",      64'(done),      64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Zero-length command
    issue(1'b0, 20'h00100, 20'd8, 5'd0);
    check("len0_done",   64'(done),      64'd1);
    check("len0_we",     64'(mem_we),    64'd0);
    check("len0_rvalid", 64'(rsp_valid), 64'd0);
    @(negedge CLK);
    check("len0_done_off", 64'(done), 64'd0);
    @(negedge CLK);

    // Back-to-back load, consumer always ready
    issue(1'b0, 20'h00000, 20'd64, 5'd4);
    check("ld4_lat", 64'(rsp_valid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge CLK);
      check("ld4_valid", 64'(rsp_valid), 64'd1);
      check("ld4_data",  rsp_data, exp_vec(64*b));
      check("ld4_last",  64'(rsp_last), 64'(b == 3));
      check("ld4_nodone", 64'(done), 64'd0);
    end
    @(negedge CLK);
    check("ld4_done",    64'(done),      64'd1);
    check("ld4_vclear",  64'(rsp_valid), 64'd0);
    @(negedge CLK);

    // Load with back-pressure on beat 1
    issue(1'b0, 20'h00100, 20'd3, 5'd3);
    @(negedge CLK);
    check("bp_b0", rsp_data, exp_vec(32'h100));
    @(negedge CLK);
    check("bp_b1", rsp_data, exp_vec(32'h103));
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("bp_hold_v",    64'(rsp_valid), 64'd1);
      check("bp_hold_data", rsp_data, exp_vec(32'h103));
      check("bp_hold_last", 64'(rsp_last), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_b2",      rsp_data, exp_vec(32'h106));
    check("bp_b2_last", 64'(rsp_last), 64'd1);
    check("bp_b2_nodone", 64'(done), 64'd0);
    @(negedge CLK);
    check("bp_done", 64'(done), 64'd1);
    @(negedge CLK);

    // Range abort on the first beat
    issue(1'b0, 20'd51144, 20'd1, 5'd2);
    check("oob0_v1", 64'(rsp_valid), 64'd0);
    @(negedge CLK);
    check("oob0_err",  64'(err),       64'd1);
    check("oob0_v2",   64'(rsp_valid), 64'd0);
    check("oob0_done", 64'(done),      64'd0);
    @(negedge CLK);
    check("oob0_err_off", 64'(err),       64'd0);
    check("oob0_done2",   64'(done),      64'd0);
    check("oob0_ready",   64'(req_ready), 64'd1);

    // Range abort on the second beat
    issue(1'b0, 20'd51143, 20'd1, 5'd2);
    @(negedge CLK);
    check("oob1_v",    64'(rsp_valid), 64'd1);
    check("oob1_data", rsp_data, exp_vec(51143));
    check("oob1_noerr", 64'(err), 64'd0);
    @(negedge CLK);
    check("oob1_err",  64'(err),       64'd1);
    check("oob1_v2",   64'(rsp_valid), 64'd0);
    check("oob1_done", 64'(done),      64'd0);
    @(negedge CLK);

    // Store burst
    issue(1'b1, 20'h00010, 20'd1, 5'd2);
    check("st_wready", 64'(wr_ready), 64'd1);
    wr_valid = 1'b1; wr_data = 64'h0807060504030201;
    @(negedge CLK);
    check("st_we0",   64'(mem_we),   64'd1);
    check("st_addr0", 64'(mem_addr), 64'h10);
    check("st_wd0",   mem_wd, 64'h0807060504030201);
    wr_data = 64'h1817161514131211;
    @(negedge CLK);
    check("st_we1",   64'(mem_we),   64'd1);
    check("st_addr1", 64'(mem_addr), 64'h11);
    check("st_wready_off", 64'(wr_ready), 64'd0);
    check("st_nodone", 64'(done), 64'd0);
    wr_valid = 1'b0;
    @(negedge CLK);
    check("st_done",   64'(done),   64'd1);
    check("st_we_off", 64'(mem_we), 64'd0);
    @(negedge CLK);
    check("st_done_once", 64'(done), 64'd0);
    check("st_row10", mem_row(32'h10), 64'h0807060504030201);
    check("st_row11", mem_row(32'h11), 64'h1817161514131211);
    check("st_row12", mem_row(32'h12), exp_vec(32'h12));

    // Reset during the write-enable cycle must suppress the write
    issue(1'b1, 20'h01000, 20'd0, 5'd1);
    wr_valid = 1'b1; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge CLK);
    #1;
    check("rs_we_before", 64'(mem_we), 64'd1);
    RST = 1'b1;
    #1;
    check("rs_we_after", 64'(mem_we), 64'd0);
    @(negedge CLK);
    wr_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    check("rs_ready_low", 64'(req_ready), 64'd0);
    @(negedge CLK);
    check("rs_ready_high", 64'(req_ready), 64'd1);
    check("rs_row", mem_row(32'h1000), exp_vec(32'h1000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_mem_requester.md
Name: vector_mem_requester

Overview:
- Initiator side of the 8-lane strided data-memory interface.
- Accepts vector load/store burst commands from the vector pipeline and sequences one memory beat per cycle.
- Drives the address, write-enable and write data to the data memory, and returns read vectors through a valid/ready response channel.
- Memory contract: each access touches lanes at Addr+8*i, i=0..7. Reads are combinational. Writes commit on the falling CLK edge while WE=1.

Parameters:
ADDR_W, 20, memory address width
LANES, 8, vector lanes per beat
PIX_SIZE, 8, bits per lane
LANE_STRIDE, 8, address distance between lanes within one beat
MEM_DEPTH, 51200, valid entries; highest legal lane address is MEM_DEPTH-1
LEN_W, 5, burst length width (max 31 beats)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid&req_ready
req_we  in  1  1=store burst, 0=load burst
req_addr  in  ADDR_W  base address of beat 0
req_stride  in  ADDR_W  address increment between beats (mod 2^ADDR_W)
req_len  in  LEN_W  number of beats
wr_valid  in  1  store data valid
wr_ready  out  1  store data accepted
wr_data  in  LANES*PIX_SIZE  store vector, lane i at bits [8i+7:8i]
rsp_valid  out  1  load vector valid
rsp_ready  in  1  consumer accepts load vector
rsp_data  out  LANES*PIX_SIZE  load vector
rsp_last  out  1  marks final beat of a load burst
done  out  1  one-cycle pulse at burst completion
err  out  1  one-cycle pulse on range abort
mem_addr  out  ADDR_W  to memory Addr
mem_we  out  1  to memory WE
mem_wd  out  LANES*PIX_SIZE  to memory WD
mem_rd  in  LANES*PIX_SIZE  from memory RD

Behaviour:
- Reset (async): state=IDLE. Clear to 0: req_ready, wr_ready, rsp_valid, rsp_last, done, err, mem_we, mem_addr, mem_wd, rsp_data. mem_we must fall immediately so no falling-edge write occurs after RST rises.
- req_ready is registered: goes to 1 on the first rising edge after RST deasserts, and is 1 only in IDLE.
- IDLE, on accept: latch we, base, stride, cnt=req_len.
  - req_len=0: done pulses next cycle, stay IDLE, no memory access.
  - we=0: go LOAD. we=1: go STORE.
- Range check per beat: addr + (LANES-1)*LANE_STRIDE is computed at ADDR_W+1 bits.
  - If the result is >MEM_DEPTH-1: no access for that beat, err pulses 1 cycle, go IDLE. Beats already transferred stay valid, and done does not pulse.
- LOAD:
  - mem_addr=cur_addr, mem_we=0.
  - Capture mem_rd into rsp_data when rsp_valid=0 or rsp_ready=1. On capture: rsp_valid=1, rsp_last=(cnt==1), cur_addr+=stride, cnt-=1.
  - While rsp_valid&!rsp_ready: hold rsp_data, rsp_last and cur_addr.
  - Throughput: 1 beat/cycle with rsp_ready tied high. Latency: first rsp_valid 2 cycles after accept.
  - After the last beat is accepted by the consumer: done pulses, rsp_valid clears (unless a new capture), go IDLE.
- STORE:
  - wr_ready=1.
  - On wr_valid&wr_ready, at the rising edge: mem_addr=cur_addr, mem_wd=wr_data, mem_we=1 for exactly that following cycle. The memory commits on that cycle's falling edge. Then cur_addr+=stride, cnt-=1.
  - Cycles without wr_valid: mem_we=0.
  - After the last beat's mem_we cycle: done pulses, wr_ready=0, go IDLE.
- Range-fail beat: mem_we stays 0 and the beat is not written.
- No new command is accepted before done or err.
- Address wrap: cur_addr wraps mod 2^ADDR_W. A wrapped address is then caught by the range check.
- Overlapping lane sets across beats are legal. Later beats overwrite earlier ones.

Test Plan:
1. Reset mid-STORE: assert RST during the mem_we cycle -> mem_we=0 before the next falling edge, target bytes unchanged; after release req_ready=1 after one cycle.
2. Store len=2, addr=0x00010, stride=1, wr_data 0x0807060504030201 then 0x1817161514131211, memory model -> bytes 0x10,0x18,..,0x48 hold 01..08; bytes 0x11,0x19,..,0x49 hold 11..18; done pulses once.
3. Load len=4, addr=0, stride=64, rsp_ready=1 -> 4 consecutive rsp_valid cycles matching the model, rsp_last only on beat 4, first valid 2 cycles after accept.
4. Load len=3 with rsp_ready low for 3 cycles on beat 2 -> rsp_data and rsp_last held stable, no beat lost or duplicated, done after beat 3 accepted.
5. Load addr=51200-57+1=51144, len=2, stride=1 -> beat 0 is error-free? No: 51144+56=51200 exceeds the limit, so err pulses, no rsp_valid, no done. Repeat with addr=51143 -> beat 0 returned, beat 1 aborts with err.
6. len=0 command -> done pulses 1 cycle after accept, mem_we stays 0, no rsp_valid.
